// File: rtl/seg7_pkg.sv
// Shared constants for 7-segment display encoding/decoding.
// Patterns are active-low, bit6=a ... bit0=g.
package seg7_pkg;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_PATTERNS [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern to its hex nibble.
// legal is low for any code outside the 16-entry table.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             legal,
  output logic [3:0]       nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PATTERNS[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed active-low 7-segment bus back into per-digit hex nibbles,
// accepting a select/segment combination only after it has been stable long enough.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel_n,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    code_err,
  output logic                    sel_err,
  output logic                    frame_done
);

  localparam int IN_W  = NUM_DIGITS + SEG_W;
  localparam int CNT_W = 8;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [IN_W-1:0]  BLANK_BUS = {{NUM_DIGITS{1'b1}}, SEG_BLANK};

  logic [IN_W-1:0]         s1, s2, prev;
  logic [CNT_W-1:0]        count;
  logic [NUM_DIGITS-1:0]   seen;

  logic                    stable, capture;
  logic [NUM_DIGITS-1:0]   s2_sel_n, sel_mask;
  logic [SEG_W-1:0]        s2_seg;
  logic                    legal;
  logic [3:0]              nibble;
  logic [3:0]              low_cnt;
  logic [IDX_W-1:0]        sel_idx;

  logic [4*NUM_DIGITS-1:0] value_d;
  logic [NUM_DIGITS-1:0]   valid_d, seen_d;
  logic                    update_d, code_err_d, sel_err_d, frame_d;

  assign s2_sel_n = s2[IN_W-1:SEG_W];
  assign s2_seg   = s2[SEG_W-1:0];
  assign sel_mask = ~s2_sel_n;
  assign stable   = (s2 == prev);
  // Count saturates at STABLE_CYCLES, so a held pattern hits CAP_CNT only once.
  assign capture  = stable && (count == CAP_CNT);

  seg7_pattern_decode u_decode (
    .seg    (s2_seg),
    .legal  (legal),
    .nibble (nibble)
  );

  always_comb begin
    low_cnt = 4'd0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s2_sel_n[i]) begin
        low_cnt = low_cnt + 4'd1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    value_d    = value_out;
    valid_d    = digit_valid;
    seen_d     = seen;
    update_d   = 1'b0;
    code_err_d = 1'b0;
    sel_err_d  = 1'b0;
    frame_d    = 1'b0;
    if (capture) begin
      if (low_cnt > 4'd1) begin
        sel_err_d = 1'b1;
      end else if (low_cnt == 4'd1) begin
        if (legal) begin
          value_d[{sel_idx, 2'b00} +: 4] = nibble;
          valid_d[sel_idx] = 1'b1;
          update_d         = 1'b1;
          if ((seen | sel_mask) == {NUM_DIGITS{1'b1}}) begin
            frame_d = 1'b1;
            seen_d  = '0;
          end else begin
            seen_d = seen | sel_mask;
          end
        end else begin
          code_err_d       = 1'b1;
          valid_d[sel_idx] = 1'b0;
          seen_d[sel_idx]  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= BLANK_BUS;
      s2          <= BLANK_BUS;
      prev        <= BLANK_BUS;
      count       <= '0;
      seen        <= '0;
      value_out   <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      code_err    <= 1'b0;
      sel_err     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      s1          <= {dig_sel_n, seg_in};
      s2          <= s1;
      prev        <= s2;
      if (!stable)                count <= '0;
      else if (count != SAT_CNT)  count <= count + CNT_W'(1);
      seen        <= seen_d;
      value_out   <= value_d;
      digit_valid <= valid_d;
      update      <= update_d;
      code_err    <= code_err_d;
      sel_err     <= sel_err_d;
      frame_done  <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: a history-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_seg7_scan_capture;
  localparam int ND = 4;
  localparam int S  = 4;
  localparam int IW = ND + 7;

  logic            clk;
  logic            rst_n;
  logic [6:0]      seg_in;
  logic [ND-1:0]   dig_sel_n;
  logic [4*ND-1:0] value_out;
  logic [ND-1:0]   digit_valid;
  logic            update, code_err, sel_err, frame_done;

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel_n   (dig_sel_n),
    .value_out   (value_out),
    .digit_valid (digit_valid),
    .update      (update),
    .code_err    (code_err),
    .sel_err     (sel_err),
    .frame_done  (frame_done)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int n_upd = 0, n_cerr = 0, n_serr = 0, n_frame = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: keeps the raw sampled input stream; a capture happens when the
  // doubly-delayed stream has shown the same value for exactly S+1 samples
  logic [IW:0]     hist[$];
  logic [6:0]      pat_tbl [16];
  logic [4*ND-1:0] m_val;
  logic [ND-1:0]   m_valid, m_seen;
  logic            m_upd, m_cerr, m_serr, m_frame;

  initial begin
    pat_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  end

  function automatic int lookup(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (pat_tbl[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back({1'b1, {IW{1'b0}}});
    for (int i = 0; i < 3; i++) hist.push_back({1'b0, {IW{1'b1}}});
    m_val = '0; m_valid = '0; m_seen = '0;
    m_upd = 0; m_cerr = 0; m_serr = 0; m_frame = 0;
  endtask

  task automatic model_step();
    int idx, run, j, lows, dig, code;
    logic [ND-1:0] sel;
    logic [6:0] seg;
    m_upd = 0; m_cerr = 0; m_serr = 0; m_frame = 0;
    idx = hist.size() - 2;
    run = 1;
    j = idx - 1;
    while (j >= 0 && hist[j] == hist[idx] && run < S + 2) begin
      run++;
      j--;
    end
    if (run == S + 1) begin
      sel = hist[idx][IW-1:7];
      seg = hist[idx][6:0];
      lows = 0; dig = 0;
      for (int i = 0; i < ND; i++) if (!sel[i]) begin lows++; dig = i; end
      if (lows > 1) m_serr = 1;
      else if (lows == 1) begin
        code = lookup(seg);
        if (code >= 0) begin
          m_val[4*dig +: 4] = 4'(code);
          m_valid[dig] = 1'b1;
          m_seen[dig]  = 1'b1;
          m_upd = 1;
          if (m_seen == {ND{1'b1}}) begin m_frame = 1; m_seen = '0; end
        end else begin
          m_cerr = 1;
          m_valid[dig] = 1'b0;
          m_seen[dig]  = 1'b0;
        end
      end
    end
    hist.push_back({1'b0, dig_sel_n, seg_in});
    if (hist.size() > S + 5) void'(hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // scoreboard compare on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      chk("value_out", 32'(value_out), 32'(m_val));
      chk("digit_valid", 32'(digit_valid), 32'(m_valid));
      chk("pulses", {28'd0, update, code_err, sel_err, frame_done},
          {28'd0, m_upd, m_cerr, m_serr, m_frame});
      chk("exclusive", 32'(32'(update) + 32'(code_err) + 32'(sel_err) <= 1 &&
                          (!frame_done || update)), 32'd1);
      if (update)     n_upd++;
      if (code_err)   n_cerr++;
      if (sel_err)    n_serr++;
      if (frame_done) n_frame++;
    end
  end

  // driver: hold a bus value for n rising edges, return just after a falling edge
  task automatic show(input logic [ND-1:0] s, input logic [6:0] g, input int n);
    dig_sel_n = s;
    seg_in    = g;
    repeat (n) @(negedge clk);
    #2;
  endtask

  int b_upd, b_cerr, b_serr, b_frame;
  logic [6:0] scan_a [4];
  logic [6:0] scan_b [4];

  initial begin
    rst_n = 1'b1; seg_in = 7'h7F; dig_sel_n = '1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seg_in    = 7'($urandom_range(0, 127));
      dig_sel_n = 4'($urandom_range(0, 15));
    end
    @(negedge clk); #1;
    chk("rst_value", 32'(value_out), 32'd0);
    chk("rst_valid", 32'(digit_valid), 32'd0);
    chk("rst_pulses", {28'd0, update, code_err, sel_err, frame_done}, 32'd0);
    seg_in = 7'h7F; dig_sel_n = '1;
    #1 rst_n = 1'b1;
    show('1, 7'h7F, 10);
    chk("post_rst_value", 32'(value_out), 32'd0);
    chk("post_rst_pulses", 32'(n_upd + n_cerr + n_serr + n_frame), 32'd0);

    // stable capture: update exactly at the 7th rising edge
    b_upd = n_upd;
    show(4'b1110, 7'b0100100, 6);
    chk("cap_early", 32'(update), 32'd0);
    @(negedge clk); #1;
    chk("cap_update", 32'(update), 32'd1);
    chk("cap_value", 32'(value_out[3:0]), 32'd5);
    chk("cap_valid", 32'(digit_valid), 32'b0001);
    show(4'b1110, 7'b0100100, 10);
    chk("cap_once", 32'(n_upd - b_upd), 32'd1);

    // glitch shorter than S+1 samples
    b_upd = n_upd;
    show(4'b1101, 7'b0000110, 3);
    show('1, 7'h7F, 10);
    chk("glitch_upd", 32'(n_upd - b_upd), 32'd0);
    chk("glitch_valid", 32'(digit_valid), 32'b0001);

    // illegal code on a loaded digit
    show(4'b1011, 7'b0001111, 10);
    chk("load7_value", 32'(value_out[11:8]), 32'd7);
    chk("load7_valid", 32'(digit_valid), 32'b0101);
    b_cerr = n_cerr;
    show(4'b1011, 7'b1111110, 10);
    chk("illegal_cerr", 32'(n_cerr - b_cerr), 32'd1);
    chk("illegal_valid", 32'(digit_valid), 32'b0001);
    chk("illegal_hold", 32'(value_out), 32'h0705);
    show('1, 7'h7F, 6);

    // two selects low
    b_upd = n_upd; b_serr = n_serr;
    show(4'b1100, 7'b0000001, 10);
    chk("sel_serr", 32'(n_serr - b_serr), 32'd1);
    chk("sel_noupd", 32'(n_upd - b_upd), 32'd0);
    chk("sel_value", 32'(value_out), 32'h0705);
    show('1, 7'h7F, 6);

    // two full scans, each closing a frame
    scan_a = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
    scan_b = '{7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001};
    b_upd = n_upd; b_frame = n_frame;
    for (int d = 0; d < 4; d++) show(~(4'b0001 << d), scan_a[d], 8);
    show('1, 7'h7F, 6);
    chk("scan1_upd", 32'(n_upd - b_upd), 32'd4);
    chk("scan1_value", 32'(value_out), 32'h4321);
    chk("scan1_valid", 32'(digit_valid), 32'hF);
    chk("scan1_frame", 32'(n_frame - b_frame), 32'd1);
    for (int d = 0; d < 4; d++) show(~(4'b0001 << d), scan_b[d], 8);
    show('1, 7'h7F, 6);
    chk("scan2_value", 32'(value_out), 32'hCBA9);
    chk("scan2_frame", 32'(n_frame - b_frame), 32'd2);

    // reset in the middle of a stable period
    show(4'b1110, 7'b0000000, 3);
    rst_n = 1'b0;
    show(4'b1110, 7'b0000000, 2);
    chk("midrst_value", 32'(value_out), 32'd0);
    chk("midrst_valid", 32'(digit_valid), 32'd0);
    b_upd = n_upd;
    rst_n = 1'b1;
    show(4'b1110, 7'b0000000, 10);
    chk("midrst_upd", 32'(n_upd - b_upd), 32'd1);
    chk("midrst_recap", 32'(value_out), 32'h0008);
    chk("midrst_rvalid", 32'(digit_valid), 32'b0001);

    show('1, 7'h7F, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
